// File: rtl/regdst_sel_pipe_if.sv
// Request/response bundle for regdst_sel_pipe: candidate addresses in, selected
// destination out, plus the hazard probe.
interface regdst_sel_pipe_if #(
    parameter int unsigned AW = 5
) ();
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [AW-1:0] c;
    logic [1:0]    sel;
    logic          wen_in;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] out_addr;
    logic          out_wen;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] cmp_addr;
    logic          hit;

    modport master (
        output a, b, c, sel, wen_in, in_valid, out_ready, cmp_addr,
        input  in_ready, out_addr, out_wen, out_valid, hit
    );

    modport slave (
        input  a, b, c, sel, wen_in, in_valid, out_ready, cmp_addr,
        output in_ready, out_addr, out_wen, out_valid, hit
    );
endinterface

// File: rtl/regdst_sel_pipe.sv
// Destination-register select with a 2-entry skid buffer and pending-write probe.
// Optional macro REGDST_ZERO_SUPPRESS_EN: treat address 0 as never written.
module regdst_sel_pipe #(
    parameter int unsigned AW        = 5,
    parameter int unsigned LINK_ADDR = 31
) (
    input  logic           clk,
    input  logic           rst,
    regdst_sel_pipe_if.slave bus
);
    localparam logic [AW-1:0] LINK_C = AW'(LINK_ADDR);
    localparam logic [AW-1:0] ZERO_C = {AW{1'b0}};

    function automatic logic [AW-1:0] resolve_addr(
        input logic [1:0]    sel,
        input logic [AW-1:0] a,
        input logic [AW-1:0] b,
        input logic [AW-1:0] c
    );
        logic [AW-1:0] r;
        case (sel)
            2'b00:   r = a;
            2'b01:   r = b;
            2'b10:   r = LINK_C;
            2'b11:   r = c;
            default: r = a;
        endcase
        return r;
    endfunction

    logic          main_valid_r, main_wen_r;
    logic [AW-1:0] main_addr_r;
    logic          skid_valid_r, skid_wen_r;
    logic [AW-1:0] skid_addr_r;
    logic          in_ready_r;

    logic          main_valid_nxt_s, main_wen_nxt_s;
    logic [AW-1:0] main_addr_nxt_s;
    logic          skid_valid_nxt_s, skid_wen_nxt_s;
    logic [AW-1:0] skid_addr_nxt_s;

    logic [AW-1:0] new_addr_s;
    logic          new_wen_s;
    logic          accept_s;
    logic          xfer_s;

    // Resolve the incoming request and its effective write enable
    always_comb begin
        new_addr_s = resolve_addr(bus.sel, bus.a, bus.b, bus.c);
`ifdef REGDST_ZERO_SUPPRESS_EN
        if (new_addr_s == ZERO_C) begin
            new_wen_s = 1'b0;
        end else begin
            new_wen_s = bus.wen_in;
        end
`else
        new_wen_s = bus.wen_in;
`endif
        accept_s = bus.in_valid & in_ready_r;
        xfer_s   = main_valid_r & bus.out_ready;
    end

    // Skid-buffer next state; a full skid implies no accept this cycle
    always_comb begin
        main_valid_nxt_s = main_valid_r;
        main_addr_nxt_s  = main_addr_r;
        main_wen_nxt_s   = main_wen_r;
        skid_valid_nxt_s = skid_valid_r;
        skid_addr_nxt_s  = skid_addr_r;
        skid_wen_nxt_s   = skid_wen_r;
        if (skid_valid_r) begin
            if (xfer_s) begin
                main_valid_nxt_s = 1'b1;
                main_addr_nxt_s  = skid_addr_r;
                main_wen_nxt_s   = skid_wen_r;
                skid_valid_nxt_s = 1'b0;
            end else begin
                skid_valid_nxt_s = 1'b1;
            end
        end else if (!main_valid_r || xfer_s) begin
            if (accept_s) begin
                main_valid_nxt_s = 1'b1;
                main_addr_nxt_s  = new_addr_s;
                main_wen_nxt_s   = new_wen_s;
            end else begin
                main_valid_nxt_s = 1'b0;
            end
        end else begin
            if (accept_s) begin
                skid_valid_nxt_s = 1'b1;
                skid_addr_nxt_s  = new_addr_s;
                skid_wen_nxt_s   = new_wen_s;
            end else begin
                skid_valid_nxt_s = 1'b0;
            end
        end
    end

    // State registers; reset discards any in-flight entries
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_r <= 1'b0;
            main_addr_r  <= ZERO_C;
            main_wen_r   <= 1'b0;
            skid_valid_r <= 1'b0;
            skid_addr_r  <= ZERO_C;
            skid_wen_r   <= 1'b0;
            in_ready_r   <= 1'b1;
        end else begin
            main_valid_r <= main_valid_nxt_s;
            main_addr_r  <= main_addr_nxt_s;
            main_wen_r   <= main_wen_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
            skid_addr_r  <= skid_addr_nxt_s;
            skid_wen_r   <= skid_wen_nxt_s;
            in_ready_r   <= ~skid_valid_nxt_s;
        end
    end

    // Pending-write probe across both entries
    always_comb begin
        bus.hit = 1'b0;
        if (main_valid_r && main_wen_r && (main_addr_r == bus.cmp_addr)) begin
            bus.hit = 1'b1;
        end else if (skid_valid_r && skid_wen_r && (skid_addr_r == bus.cmp_addr)) begin
            bus.hit = 1'b1;
        end else begin
            bus.hit = 1'b0;
        end
`ifdef REGDST_ZERO_SUPPRESS_EN
        if (bus.cmp_addr == ZERO_C) begin
            bus.hit = 1'b0;
        end else begin
            bus.hit = bus.hit;
        end
`endif
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = main_valid_r;
    assign bus.out_addr  = main_addr_r;
    assign bus.out_wen   = main_wen_r;
endmodule

// File: tb/tb_regdst_sel_pipe.sv
// Directed, table-driven bench for regdst_sel_pipe: each record is applied for
// one clock edge and the outputs are compared just after that edge.
module tb_regdst_sel_pipe;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regdst_sel_pipe_if #(.AW(AW)) bus ();

    regdst_sel_pipe #(.AW(AW), .LINK_ADDR(31)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic          rst;
        logic [1:0]    sel;
        logic [AW-1:0] a, b, c;
        logic          wen_in, in_valid, out_ready;
        logic [AW-1:0] cmp;
        logic          e_ov;
        logic [AW-1:0] e_addr;
        logic          e_wen, e_ir, e_hit;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

`ifdef REGDST_ZERO_SUPPRESS_EN
    localparam logic ZS = 1'b1;
`else
    localparam logic ZS = 1'b0;
`endif

    function automatic vec_t mk(int r, int s, int a, int b, int c, int w, int iv, int ordy,
                                int cmp, int ov, int addr, int ewen, int ir, int h);
        vec_t v;
        v.rst = r[0];       v.sel = s[1:0];
        v.a = a[AW-1:0];    v.b = b[AW-1:0];    v.c = c[AW-1:0];
        v.wen_in = w[0];    v.in_valid = iv[0]; v.out_ready = ordy[0];
        v.cmp = cmp[AW-1:0];
        v.e_ov = ov[0];     v.e_addr = addr[AW-1:0];
        v.e_wen = ewen[0];  v.e_ir = ir[0];     v.e_hit = h[0];
        return v;
    endfunction

    task automatic apply(input vec_t v, input int idx);
        logic bad;
        @(negedge clk);
        rst = v.rst;
        bus.sel = v.sel; bus.a = v.a; bus.b = v.b; bus.c = v.c;
        bus.wen_in = v.wen_in; bus.in_valid = v.in_valid;
        bus.out_ready = v.out_ready; bus.cmp_addr = v.cmp;
        @(posedge clk);
        #1;
        bad = 1'b0;
        n_vec++;
        if (bus.out_valid !== v.e_ov) begin
            $display("FAIL vec%0d out_valid got %b want %b", idx, bus.out_valid, v.e_ov); bad = 1'b1;
        end
        if (bus.out_addr !== v.e_addr) begin
            $display("FAIL vec%0d out_addr got %0d want %0d", idx, bus.out_addr, v.e_addr); bad = 1'b1;
        end
        if (bus.out_wen !== v.e_wen) begin
            $display("FAIL vec%0d out_wen got %b want %b", idx, bus.out_wen, v.e_wen); bad = 1'b1;
        end
        if (bus.in_ready !== v.e_ir) begin
            $display("FAIL vec%0d in_ready got %b want %b", idx, bus.in_ready, v.e_ir); bad = 1'b1;
        end
        if (bus.hit !== v.e_hit) begin
            $display("FAIL vec%0d hit got %b want %b", idx, bus.hit, v.e_hit); bad = 1'b1;
        end
        if (bad) n_bad++;
    endtask

    initial begin
        bus.sel = 2'b00; bus.a = '0; bus.b = '0; bus.c = '0;
        bus.wen_in = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.cmp_addr = '0;

        //          rst sel a  b  c  w iv ordy cmp | ov addr wen ir hit
        tbl.push_back(mk(1, 0, 3, 7, 12, 1, 1, 1, 0,   0, 0,  0, 1, 0));
        // select: a, b, LINK, c, one cycle after each accept
        tbl.push_back(mk(0, 0, 3, 7, 12, 1, 1, 1, 3,   1, 3,  1, 1, 1));
        tbl.push_back(mk(0, 1, 3, 7, 12, 1, 1, 1, 7,   1, 7,  1, 1, 1));
        tbl.push_back(mk(0, 2, 3, 7, 12, 1, 1, 1, 31,  1, 31, 1, 1, 1));
        tbl.push_back(mk(0, 3, 3, 7, 12, 1, 1, 1, 12,  1, 12, 1, 1, 1));
        tbl.push_back(mk(0, 0, 3, 7, 12, 1, 0, 1, 12,  0, 12, 1, 1, 0));
        // stall/skid: 5 then 9 with out_ready low, extra request ignored
        tbl.push_back(mk(0, 0, 5, 7, 12, 1, 1, 0, 5,   1, 5,  1, 1, 1));
        tbl.push_back(mk(0, 0, 9, 7, 12, 1, 1, 0, 9,   1, 5,  1, 0, 1));
        tbl.push_back(mk(0, 0, 11, 7, 12, 1, 1, 0, 11, 1, 5,  1, 0, 0));
        tbl.push_back(mk(0, 0, 11, 7, 12, 1, 0, 1, 5,  1, 9,  1, 1, 0));
        tbl.push_back(mk(0, 0, 11, 7, 12, 1, 0, 1, 9,  0, 9,  1, 1, 0));
        // hazard probe
        tbl.push_back(mk(0, 0, 8, 7, 12, 1, 1, 0, 8,   1, 8,  1, 1, 1));
        tbl.push_back(mk(0, 0, 8, 7, 12, 1, 0, 0, 9,   1, 8,  1, 1, 0));
        tbl.push_back(mk(0, 0, 8, 7, 12, 0, 1, 0, 8,   1, 8,  1, 0, 1));
        tbl.push_back(mk(0, 0, 8, 7, 12, 0, 0, 1, 8,   1, 8,  0, 1, 0));
        tbl.push_back(mk(0, 0, 8, 7, 12, 0, 0, 1, 8,   0, 8,  0, 1, 0));
        // full throughput: 8 back-to-back requests, no bubbles
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 1, 0, 16 + i, 12, 1, 1, 1, 16 + i, 1, 16 + i, 1, 1, 1));
        tbl.push_back(mk(0, 1, 0, 2, 12, 1, 0, 1, 23,  0, 23, 1, 1, 0));
        // address 0 handling depends on the zero-suppress build
        tbl.push_back(mk(0, 0, 0, 2, 12, 1, 1, 1, 0,   1, 0,  int'(!ZS), 1, int'(!ZS)));
        tbl.push_back(mk(0, 0, 0, 2, 12, 1, 0, 1, 0,   0, 0,  int'(!ZS), 1, 0));
        // reset mid-operation with both entries full
        tbl.push_back(mk(0, 0, 4, 2, 12, 1, 1, 0, 4,   1, 4,  1, 1, 1));
        tbl.push_back(mk(0, 0, 6, 2, 12, 1, 1, 0, 6,   1, 4,  1, 0, 1));
        tbl.push_back(mk(1, 0, 10, 2, 12, 1, 1, 1, 4,  0, 0,  0, 1, 0));
        tbl.push_back(mk(0, 0, 13, 2, 12, 1, 1, 1, 13, 1, 13, 1, 1, 1));
        tbl.push_back(mk(0, 0, 13, 2, 12, 1, 0, 1, 13, 0, 13, 1, 1, 0));

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
